cache_refill_ctrl: RTL
======================

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 Parameter ADDRESS_BITS, default 32, SHALL set the byte-address width.
REQ-002 Parameter BLOCK_BITS, default 4, SHALL set log2 block bytes; WORDS = 2^(BLOCK_BITS-2) 32-bit words per block.
REQ-003 Parameter TIMEOUT, default 64, SHALL set the maximum REQ-state cycles per beat before abort.
REQ-004 Ports SHALL be, one per line:
  clk  in  1  clock, all state on rising edge
  rst  in  1  reset, asynchronous, active-low
  miss_valid  in  1  cache reports a miss
  miss_addr  in  ADDRESS_BITS  missing byte address
  miss_ready  out  1  controller can accept a miss
  mem_req  out  1  backing-memory word read request
  mem_addr  out  ADDRESS_BITS  word-aligned read address
  mem_ack  in  1  memory returns mem_rdata this cycle
  mem_rdata  in  32  read data
  fill_valid  out  1  one word to write into the cache line
  fill_addr  out  ADDRESS_BITS  byte address of fill word
  fill_data  out  32  fill word
  fill_last  out  1  final word of the block
  refill_done  out  1  one-cycle completion pulse
  refill_err  out  1  one-cycle timeout pulse
  refill_count  out  16  completed refills, saturating

Function
REQ-005 The FSM SHALL have states IDLE, REQ, FILL, DONE; miss_ready SHALL be 1 only in IDLE.
REQ-006 On a rising edge with miss_valid&miss_ready, the block SHALL latch base = miss_addr with low BLOCK_BITS cleared, start = miss_addr[BLOCK_BITS-1:2], beat = 0, and enter REQ.
REQ-007 In REQ, mem_req SHALL be 1 and mem_addr = base + 4*((start+beat) mod WORDS), held stable until mem_ack (critical word first, wrap within block).
REQ-008 On mem_ack in REQ, the block SHALL register mem_rdata/mem_addr into fill_data/fill_addr and enter FILL; mem_ack outside REQ SHALL be ignored.
REQ-009 In FILL, fill_valid SHALL be 1 for exactly one cycle, fill_last = (beat == WORDS-1); next state DONE if last, else REQ with beat+1.
REQ-010 In DONE, refill_done SHALL pulse one cycle, refill_count SHALL increment unless already 0xFFFF, then IDLE.
REQ-011 With zero-wait memory (ack in first REQ cycle), refill_done SHALL be high in the cycle after edge 2*WORDS counted from the accepting edge (8 for BLOCK_BITS=4); miss_ready SHALL return one cycle later.
REQ-012 A per-beat counter SHALL clear on entering REQ; if TIMEOUT consecutive REQ cycles pass without mem_ack, refill_err SHALL pulse one cycle, no further fill_valid SHALL occur, refill_count SHALL not change, and the FSM SHALL return to IDLE.
REQ-013 mem_ack on the cycle the counter reaches TIMEOUT SHALL win (beat accepted, no error).
REQ-014 miss_valid while not in IDLE SHALL be ignored, not queued.
REQ-015 fill_valid, refill_done, and refill_err SHALL never be high in the same cycle.

Reset
REQ-016 rst low SHALL immediately force IDLE, miss_ready=1 after release, and all other outputs, including refill_count, to 0.
REQ-017 Reset mid-refill SHALL abort without any subsequent fill_valid or refill_done.

Structure
REQ-018 The FSM state enum and the WORDS derivation SHALL live in a shared package cache_pkg.
REQ-019 The TIMEOUT counter SHALL be a sub-module refill_watchdog (clear, enable, expired).

Verification
REQ-020 miss_addr 0x00001008, ack every REQ cycle -> mem_addr sequence 0x1008, 0x100C, 0x1000, 0x1004; fill_last only on 0x1004; refill_done 8 cycles after acceptance.
REQ-021 Ack delayed 3 cycles per beat -> mem_addr held constant during wait; 4 fill_valid pulses; refill_count 0->1.
REQ-022 No ack with TIMEOUT=64 -> refill_err one pulse after 64 REQ cycles; no fill_valid; refill_count unchanged; miss_ready 1 next cycle.
REQ-023 Second miss_valid during a refill -> ignored; exactly one refill observed.
REQ-024 rst low during beat 2 -> outputs 0 at once; no refill_done; a new miss after release completes normally.
REQ-025 Preload refill_count to 0xFFFF via 65535 refills (or force) -> further refill_done leaves count at 0xFFFF.

Source files
------------

// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the cache refill controller: the refill FSM state
// encoding, common bus widths and the block-size to word-count derivation.
// Ports: none (package).
// -----------------------------------------------------------------------------
package cache_pkg;

  // Refill sequence: wait for a miss, request one word, hand it to the cache,
  // repeat per word, then report completion.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } refill_state_t;

  localparam int DATA_BITS  = 32;
  localparam int COUNT_BITS = 16;

  // A block of 2^blockBits bytes holds 2^(blockBits-2) 32-bit words.
  function automatic int wordsPerBlock(input int blockBits);
    return 1 << (blockBits - 2);
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// -----------------------------------------------------------------------------
// cache_refill_ctrl_if
// Bundles the three faces of the refill controller: the miss handshake from
// the cache, the word-read channel to backing memory, and the line-fill plus
// status outputs back to the cache.
// Modports:
//   master - the refill controller (drives miss_ready, mem_req/mem_addr,
//            fill_*, refill_done/err/count)
//   slave  - the surrounding cache and memory (drive miss_valid/miss_addr,
//            mem_ack/mem_rdata)
// -----------------------------------------------------------------------------
interface cache_refill_ctrl_if #(
  parameter int ADDRESS_BITS = 32
);
  import cache_pkg::*;

  logic                    miss_valid;
  logic [ADDRESS_BITS-1:0] miss_addr;
  logic                    miss_ready;

  logic                    mem_req;
  logic [ADDRESS_BITS-1:0] mem_addr;
  logic                    mem_ack;
  logic [DATA_BITS-1:0]    mem_rdata;

  logic                    fill_valid;
  logic [ADDRESS_BITS-1:0] fill_addr;
  logic [DATA_BITS-1:0]    fill_data;
  logic                    fill_last;

  logic                    refill_done;
  logic                    refill_err;
  logic [COUNT_BITS-1:0]   refill_count;

  modport master (
    input  miss_valid, miss_addr, mem_ack, mem_rdata,
    output miss_ready, mem_req, mem_addr,
    output fill_valid, fill_addr, fill_data, fill_last,
    output refill_done, refill_err, refill_count
  );

  modport slave (
    output miss_valid, miss_addr, mem_ack, mem_rdata,
    input  miss_ready, mem_req, mem_addr,
    input  fill_valid, fill_addr, fill_data, fill_last,
    input  refill_done, refill_err, refill_count
  );

endinterface

// File: rtl/refill_watchdog.sv
// -----------------------------------------------------------------------------
// refill_watchdog
// Counts consecutive request cycles that did not receive an acknowledge and
// flags the cycle in which the TIMEOUT-th such cycle occurs.
// Ports:
//   clk       in  clock
//   rst       in  asynchronous active-low reset
//   i_clear   in  restart the count (held while no beat is outstanding)
//   i_enable  in  current cycle is a request cycle without acknowledge
//   o_expired out this cycle is the TIMEOUT-th unacknowledged request cycle
// -----------------------------------------------------------------------------
module refill_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  // The count only has to reach TIMEOUT-1: the cycle that would make it
  // TIMEOUT is the one that reports expiry, so it is never stored.
  localparam int CNT_BITS = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(TIMEOUT - 1);

  logic [CNT_BITS-1:0] r_count;

  // Count unacknowledged request cycles; stick at the limit until cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LAST)) begin
      r_count <= r_count + CNT_BITS'(1);
    end
  end

  // Gated by enable so an acknowledge arriving on the final allowed cycle
  // suppresses expiry.
  assign o_expired = i_enable && (r_count == LAST);

endmodule

// File: rtl/cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_refill_ctrl
// Refills one cache block after a miss, fetching 32-bit words from backing
// memory critical-word-first and wrapping within the block. Each returned word
// is presented to the cache for one cycle; a completion pulse and saturating
// refill counter follow the last word. A per-beat watchdog aborts a refill
// whose memory stops answering.
// Ports:
//   clk  in   clock, all state on rising edge
//   rst  in   asynchronous active-low reset
//   bus  master modport of cache_refill_ctrl_if:
//        miss_valid/miss_addr/miss_ready         miss handshake
//        mem_req/mem_addr/mem_ack/mem_rdata      word read channel
//        fill_valid/fill_addr/fill_data/fill_last line fill output
//        refill_done/refill_err/refill_count     status
// Parameters: ADDRESS_BITS (byte address width), BLOCK_BITS (log2 block bytes,
// at least 3), TIMEOUT (max unacknowledged request cycles per word).
// -----------------------------------------------------------------------------
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDRESS_BITS = 32,
  parameter int BLOCK_BITS   = 4,
  parameter int TIMEOUT      = 64
) (
  input logic                clk,
  input logic                rst,
  cache_refill_ctrl_if.master bus
);

  localparam int WORDS     = wordsPerBlock(BLOCK_BITS);
  localparam int BEAT_BITS = BLOCK_BITS - 2;

  refill_state_t r_state;
  refill_state_t w_nextState;

  logic [ADDRESS_BITS-1:0] r_baseAddr;
  logic [BEAT_BITS-1:0]    r_startWord;
  logic [BEAT_BITS-1:0]    r_beat;
  logic [ADDRESS_BITS-1:0] r_fillAddr;
  logic [DATA_BITS-1:0]    r_fillData;
  logic [COUNT_BITS-1:0]   r_refillCount;
  logic                    r_refillErr;

  logic [BEAT_BITS-1:0]    w_wordIdx;
  logic [ADDRESS_BITS-1:0] w_reqAddr;
  logic                    w_inReq;
  logic                    w_lastBeat;
  logic                    w_wdClear;
  logic                    w_wdEnable;
  logic                    w_expired;
  logic                    w_unusedAddrLsb;

  // Fills are whole words, so the byte offset within a word carries nothing.
  assign w_unusedAddrLsb = ^bus.miss_addr[1:0];

  // The word index is only BEAT_BITS wide, so the sum wraps modulo WORDS,
  // giving critical-word-first order that stays inside the block.
  assign w_wordIdx  = r_startWord + r_beat;
  assign w_reqAddr  = r_baseAddr + ADDRESS_BITS'({w_wordIdx, 2'b00});
  assign w_lastBeat = (r_beat == BEAT_BITS'(WORDS - 1));

  assign w_inReq    = (r_state == ST_REQ);
  assign w_wdClear  = !w_inReq;
  assign w_wdEnable = w_inReq && !bus.mem_ack;

  refill_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_wdClear),
    .i_enable  (w_wdEnable),
    .o_expired (w_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and state-decoded outputs. miss_ready is additionally gated by
  // rst so it stays low while reset is held and rises only after release.
  always_comb begin
    w_nextState     = r_state;
    bus.miss_ready  = 1'b0;
    bus.mem_req     = 1'b0;
    bus.mem_addr    = '0;
    bus.fill_valid  = 1'b0;
    bus.fill_last   = 1'b0;
    bus.refill_done = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        bus.miss_ready = rst;
        if (bus.miss_valid) begin
          w_nextState = ST_REQ;
        end
      end
      ST_REQ: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = w_reqAddr;
        // An acknowledge on the final allowed cycle takes priority over expiry.
        if (bus.mem_ack) begin
          w_nextState = ST_FILL;
        end else if (w_expired) begin
          w_nextState = ST_IDLE;
        end
      end
      ST_FILL: begin
        bus.fill_valid = 1'b1;
        bus.fill_last  = w_lastBeat;
        w_nextState    = w_lastBeat ? ST_DONE : ST_REQ;
      end
      ST_DONE: begin
        bus.refill_done = 1'b1;
        w_nextState     = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Refill datapath: capture the block geometry on acceptance, the returned
  // word on acknowledge, and advance the beat after each fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_baseAddr  <= '0;
      r_startWord <= '0;
      r_beat      <= '0;
      r_fillAddr  <= '0;
      r_fillData  <= '0;
    end else begin
      if ((r_state == ST_IDLE) && bus.miss_valid) begin
        r_baseAddr  <= {bus.miss_addr[ADDRESS_BITS-1:BLOCK_BITS], BLOCK_BITS'(0)};
        r_startWord <= bus.miss_addr[BLOCK_BITS-1:2];
        r_beat      <= '0;
      end
      if (w_inReq && bus.mem_ack) begin
        r_fillAddr <= w_reqAddr;
        r_fillData <= bus.mem_rdata;
      end
      if ((r_state == ST_FILL) && !w_lastBeat) begin
        r_beat <= r_beat + BEAT_BITS'(1);
      end
    end
  end

  // Status: the error pulse lands in the first idle cycle after an abort, and
  // the completion counter advances as DONE is left, saturating at all ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_refillErr   <= 1'b0;
      r_refillCount <= '0;
    end else begin
      r_refillErr <= w_expired;
      if ((r_state == ST_DONE) && (r_refillCount != '1)) begin
        r_refillCount <= r_refillCount + COUNT_BITS'(1);
      end
    end
  end

  assign bus.fill_addr    = r_fillAddr;
  assign bus.fill_data    = r_fillData;
  assign bus.refill_err   = r_refillErr;
  assign bus.refill_count = r_refillCount;

endmodule
